game_controller: RTL and testbench

Sequencing FSM for the hex-digit guessing game. It latches the switch-selected secret, accepts player guesses one at a time, and issues each guess to the external `guess_checker` through a request/done handshake. It also counts attempts and declares win or loss. The block sits between the digit selectors and the checker, and owns all game-level state.

---
 rtl/game_pkg.sv | 25 ++
 rtl/game_controller_attempt_counter.sv | 24 ++
 rtl/game_controller.sv | 177 +++++++++++++++++
 tb/tb_game_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the hex-digit guessing game.
package game_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int CODE_W     = NUM_DIGITS * DIGIT_W;

    localparam logic [3:0] WIN_COUNT = 4'd4;

    typedef enum logic [2:0] {
        IDLE,
        SET_SECRET,
        WAIT_GUESS,
        CHECK,
        EVAL,
        WIN,
        LOSE
    } game_state_t;

    // Checker counts can never legitimately exceed the digit count.
    function automatic logic [3:0] sat_count(input logic [3:0] value);
        return (value > WIN_COUNT) ? WIN_COUNT : value;
    endfunction

endpackage

// File: rtl/game_controller_attempt_counter.sv
// Per-game attempt counter with clear, increment and a last-attempt flag.
module attempt_counter #(
    parameter int MAX_GUESSES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] count,
    output logic       last
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 4'd1;
        end
    end

    // High when the next increment makes the count equal MAX_GUESSES.
    assign last = (({1'b0, count} + 5'd1) == 5'(MAX_GUESSES));

endmodule

// File: rtl/game_controller.sv
// Game sequencing FSM: secret latch, guess issue to the checker, win/lose.
// Optional duplicate-guess rejection is enabled by defining GAME_CTRL_DUP_REJECT_EN.
module game_controller
    import game_pkg::*;
#(
    parameter int MAX_GUESSES = 10,
    parameter int CHK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        lock_secret,
    input  logic [15:0] secret_in,
    input  logic        guess_valid,
    input  logic [15:0] guess,
    output logic        guess_ready,
    output logic [15:0] secret_number,
    output logic [15:0] chk_guess,
    output logic        chk_req,
    input  logic        chk_done,
    input  logic [3:0]  chk_correct,
    input  logic [3:0]  chk_wrong,
    output logic [3:0]  correct_place_count,
    output logic [3:0]  wrong_place_count,
    output logic        result_valid,
    output logic [3:0]  attempts,
    output logic        win,
    output logic        lose,
    output logic        chk_error
);

    localparam int TMO_W = $clog2(CHK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CHK_TIMEOUT - 1);

    game_state_t      state, next_state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [3:0]       held_correct, held_wrong;
    logic             accept, dup, take_done, timeout, new_game, last, is_dup;

`ifdef GAME_CTRL_DUP_REJECT_EN
    logic have_prev;

    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            have_prev <= 1'b0;
        end else if (accept) begin
            have_prev <= 1'b1;
        end
    end

    assign is_dup = have_prev && (guess == chk_guess);
`else
    assign is_dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        next_state  = state;
        guess_ready = 1'b0;
        accept      = 1'b0;
        dup         = 1'b0;
        take_done   = 1'b0;
        timeout     = 1'b0;
        new_game    = 1'b0;
        case (state)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    new_game   = 1'b1;
                    next_state = SET_SECRET;
                end
            end
            SET_SECRET: begin
                if (lock_secret) next_state = WAIT_GUESS;
            end
            WAIT_GUESS: begin
                guess_ready = 1'b1;
                if (guess_valid) begin
                    if (is_dup) begin
                        dup = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        next_state = CHECK;
                    end
                end
            end
            CHECK: begin
                if (chk_done) begin
                    take_done  = 1'b1;
                    next_state = EVAL;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout    = 1'b1;
                    next_state = WAIT_GUESS;
                end
            end
            EVAL: begin
                if (held_correct == WIN_COUNT) next_state = WIN;
                else if (last)                 next_state = LOSE;
                else                           next_state = WAIT_GUESS;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            secret_number       <= '0;
            chk_guess           <= '0;
            chk_req             <= 1'b0;
            tmo_cnt             <= '0;
            held_correct        <= '0;
            held_wrong          <= '0;
            correct_place_count <= '0;
            wrong_place_count   <= '0;
            result_valid        <= 1'b0;
            win                 <= 1'b0;
            lose                <= 1'b0;
            chk_error           <= 1'b0;
        end else begin
            chk_req      <= accept;
            result_valid <= dup || (state == EVAL);

            if (new_game) begin
                win                 <= 1'b0;
                lose                <= 1'b0;
                chk_error           <= 1'b0;
                correct_place_count <= '0;
                wrong_place_count   <= '0;
            end

            if (state == SET_SECRET && lock_secret) secret_number <= secret_in;

            if (accept) begin
                chk_guess <= guess;
                tmo_cnt   <= '0;
            end else if (state == CHECK) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            // Checker outputs are only guaranteed while chk_done is high.
            if (take_done) begin
                held_correct <= sat_count(chk_correct);
                held_wrong   <= sat_count(chk_wrong);
            end

            if (timeout) chk_error <= 1'b1;

            if (state == EVAL) begin
                correct_place_count <= held_correct;
                wrong_place_count   <= held_wrong;
                chk_error           <= 1'b0;
                win                 <= (held_correct == WIN_COUNT);
                lose                <= (held_correct != WIN_COUNT) && last;
            end
        end
    end

    attempt_counter #(
        .MAX_GUESSES (MAX_GUESSES)
    ) u_attempts (
        .clk   (clk),
        .reset (reset),
        .clear (new_game),
        .inc   (state == EVAL),
        .count (attempts),
        .last  (last)
    );

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: expected results queued when the
// checker response is driven, compared when result_valid pulses.
module tb_game_controller;

    localparam int MAXG = 3;
    localparam int TMO  = 15;

    logic        clk = 1'b0;
    logic        reset, start, lock_secret, guess_valid, chk_done;
    logic [15:0] secret_in, guess, secret_number, chk_guess;
    logic        guess_ready, chk_req, result_valid, win, lose, chk_error;
    logic [3:0]  chk_correct, chk_wrong, correct_place_count, wrong_place_count, attempts;

    typedef struct packed {
        logic [3:0] c;
        logic [3:0] w;
        logic [3:0] att;
        logic       win;
        logic       lose;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   req_count = 0;
    int   rv_count = 0;
    int   model_att = 0;

    game_controller #(
        .MAX_GUESSES (MAXG),
        .CHK_TIMEOUT (TMO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .lock_secret         (lock_secret),
        .secret_in           (secret_in),
        .guess_valid         (guess_valid),
        .guess               (guess),
        .guess_ready         (guess_ready),
        .secret_number       (secret_number),
        .chk_guess           (chk_guess),
        .chk_req             (chk_req),
        .chk_done            (chk_done),
        .chk_correct         (chk_correct),
        .chk_wrong           (chk_wrong),
        .correct_place_count (correct_place_count),
        .wrong_place_count   (wrong_place_count),
        .result_valid        (result_valid),
        .attempts            (attempts),
        .win                 (win),
        .lose                (lose),
        .chk_error           (chk_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && chk_req) req_count++;
        if (!reset && result_valid) begin
            rv_count++;
            if (sb.size() == 0) begin
                check("result_with_empty_sb", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("correct_cnt", correct_place_count, e.c);
                check("wrong_cnt", wrong_place_count, e.w);
                check("attempts", attempts, e.att);
                check("win", win, e.win);
                check("lose", lose, e.lose);
            end
        end
    end

    function automatic logic [3:0] sat4(input logic [3:0] v);
        return (v > 4'd4) ? 4'd4 : v;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic new_game(input logic [15:0] s);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ready_in_set_secret", guess_ready, 1'b0);
        secret_in   = s;
        lock_secret = 1'b1;
        tick();
        lock_secret = 1'b0;
        check("secret_latched", secret_number, s);
        model_att = 0;
    endtask

    task automatic submit(input logic [15:0] g, input logic expect_req);
        int k = 0;
        while (!guess_ready && k < 50) begin
            tick();
            k++;
        end
        check("guess_ready_wait", guess_ready, 1'b1);
        guess       = g;
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        check("chk_req_pulse", chk_req, expect_req);
    endtask

    task automatic respond(input logic [3:0] c, input logic [3:0] w, input int delay);
        exp_t e;
        tick(delay);
        e.c    = sat4(c);
        e.w    = sat4(w);
        e.att  = 4'(model_att + 1);
        e.win  = (sat4(c) == 4'd4);
        e.lose = !e.win && (model_att + 1 == MAXG);
        model_att++;
        last_exp = e;
        sb.push_back(e);
        chk_correct = c;
        chk_wrong   = w;
        chk_done    = 1'b1;
        tick();
        chk_done    = 1'b0;
        chk_correct = '0;
        chk_wrong   = '0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        check("result_arrival", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int saved;
        reset = 1'b1; start = 1'b0; lock_secret = 1'b0; guess_valid = 1'b0;
        chk_done = 1'b0; secret_in = '0; guess = '0; chk_correct = '0; chk_wrong = '0;
        tick(3);
        check("reset_outputs", {secret_number, chk_guess, chk_req, correct_place_count,
              wrong_place_count, result_valid, attempts, win, lose, chk_error, guess_ready}, '0);
        reset = 1'b0;
        tick();

        // Win on the first guess, with minimum latency.
        new_game(16'h1A2B);
        submit(16'h1A2B, 1'b1);
        check("chk_guess_latched", chk_guess, 16'h1A2B);
        respond(4'd4, 4'd0, 0);
        check("eval_gap", result_valid, 1'b0);
        tick();
        check("result_at_3_cycles", result_valid, 1'b1);
        drain();
        check("ready_in_win", guess_ready, 1'b0);

        // Loss after MAXG guesses; stray start mid-game is ignored.
        new_game(16'h1234);
        check("attempts_cleared", attempts, 4'd0);
        check("win_cleared", win, 1'b0);
        submit(16'h0000, 1'b1);
        respond(4'd1, 4'd0, 0);
        drain();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("start_ignored_ready", guess_ready, 1'b1);
        check("start_ignored_att", attempts, 4'd1);
        submit(16'h1111, 1'b1);
        respond(4'd1, 4'd0, 2);
        drain();
        submit(16'h2222, 1'b1);
        respond(4'd1, 4'd0, 1);
        drain();
        check("ready_in_lose", guess_ready, 1'b0);

        // Timeout boundary, stray done, saturation and last-guess win.
        new_game(16'h5555);
        submit(16'h0001, 1'b1);
        tick(TMO - 1);
        check("no_error_before_tmo", chk_error, 1'b0);
        check("busy_before_tmo", guess_ready, 1'b0);
        tick();
        check("error_at_tmo", chk_error, 1'b1);
        check("ready_after_tmo", guess_ready, 1'b1);
        check("att_after_tmo", attempts, 4'd0);
        saved = rv_count;
        chk_correct = 4'd4;
        chk_done = 1'b1;
        tick();
        chk_done = 1'b0;
        chk_correct = '0;
        tick(3);
        check("stray_done_ignored", rv_count, saved);
        check("stray_done_win", win, 1'b0);
        submit(16'h0002, 1'b1);
        respond(4'd0, 4'd9, 3);
        drain();
        check("error_cleared", chk_error, 1'b0);
        submit(16'h0003, 1'b1);
        respond(4'd1, 4'd1, 0);
        drain();
        submit(16'h5555, 1'b1);
        respond(4'd4, 4'd0, 0);
        drain();

        // Same guess twice.
        new_game(16'hBEEF);
        submit(16'hBEEF, 1'b1);
        respond(4'd2, 4'd1, 0);
        drain();
        saved = req_count;
`ifdef GAME_CTRL_DUP_REJECT_EN
        sb.push_back(last_exp);
        submit(16'hBEEF, 1'b0);
        drain();
        check("dup_no_req", req_count, saved);
        check("dup_attempts", attempts, 4'd1);
        check("dup_ready", guess_ready, 1'b1);
`else
        submit(16'hBEEF, 1'b1);
        respond(4'd2, 4'd1, 0);
        drain();
        check("repeat_req", req_count, saved + 1);
        check("repeat_attempts", attempts, 4'd2);
`endif

        // Reset one cycle after chk_req, then a late done.
        submit(16'h0F0F, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        check("reset_midcheck_outputs", {secret_number, chk_guess, chk_req, correct_place_count,
              wrong_place_count, result_valid, attempts, win, lose, chk_error, guess_ready}, '0);
        reset = 1'b0;
        saved = rv_count;
        chk_correct = 4'd4;
        chk_done = 1'b1;
        tick();
        chk_done = 1'b0;
        chk_correct = '0;
        check("no_req_after_reset", chk_req, 1'b0);
        tick(3);
        check("late_done_ignored", rv_count, saved);
        secret_in = 16'hAAAA;
        lock_secret = 1'b1;
        tick();
        lock_secret = 1'b0;
        check("idle_ignores_lock", secret_number, 16'h0000);
        new_game(16'hAAAA);
        check("ready_after_restart", guess_ready, 1'b1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
